issue_rat_redeem_queue: RTL and testbench
=========================================

Name: issue_rat_redeem_queue

Overview:
- Producer side of the freelist redeem interface. Collects physical registers released at rename (the previous mapping of a renamed architectural register) and returns them to issue_rat_freelist over the valid/ready redeemed handshake.
- Each released PRF is tagged with the FGR of the renaming instruction. A PRF is held until that FGR commits and is discarded if the FGR is abandoned.
- Sits between the rename stage and issue_rat_freelist.

Parameters:
- DEPTH, 8: number of queue entries; must be a power of two, at least 2.
- PRF_WIDTH, 6: width of a physical register index.
- FGR_WIDTH, 4: width of an FGR tag.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (low = in reset).
- i_release_prf  in  PRF_WIDTH  PRF released by rename.
- i_release_fgr  in  FGR_WIDTH  FGR of the releasing instruction.
- i_release_speculative  in  1  1 = hold until commit; 0 = releasable immediately.
- i_release_valid  in  1  release request.
- o_release_ready  out  1  queue not full.
- o_redeemed_prf  out  PRF_WIDTH  PRF returned to the freelist.
- o_redeemed_valid  out  1  head entry is live and committed.
- i_redeemed_ready  in  1  freelist accepts.
- i_commit_fgr  in  FGR_WIDTH  committed FGR.
- i_commit_valid  in  1  commit strobe.
- i_abandon_fgr  in  FGR_WIDTH  abandoned FGR.
- i_abandon_valid  in  1  abandon strobe.

Behaviour:
- Storage: circular buffer of DEPTH entries {prf, fgr, live, committed}, plus head and tail pointers (log2 DEPTH bits, natural wrap) and count (log2 DEPTH + 1 bits).
- Reset: asynchronously clears head, tail, count and all live/committed bits. During reset o_redeemed_valid = 0, o_redeemed_prf = 0 and o_release_ready = 1. No write occurs while reset is low.
- o_release_ready = (count != DEPTH), taken from registered state only; it has no combinational path from any input.
- Enqueue: when i_release_valid && o_release_ready, write entry[tail] and advance tail. Written values:
  - live = 1, unless i_abandon_valid && i_abandon_fgr == i_release_fgr (same-cycle abandon), in which case live = 0.
  - committed = !i_release_speculative || (i_commit_valid && i_commit_fgr == i_release_fgr).
- Commit: every live entry with fgr == i_commit_fgr sets committed = 1 on the next edge.
- Abandon: every live, uncommitted entry with fgr == i_abandon_fgr clears live on the next edge. Committed entries are never dropped.
- Same FGR committed and abandoned in one cycle: abandon wins for uncommitted entries, and such entries are not marked committed. This case is illegal upstream; the bench flags it.
- Head output:
  - o_redeemed_valid = (count != 0) && entry[head].live && entry[head].committed.
  - o_redeemed_prf = entry[head].prf; it is 0 when o_redeemed_valid = 0.
  - Both are driven from registered state, so data is visible 1 cycle after the enqueue or commit that made it eligible.
- Dequeue (handshake): o_redeemed_valid && i_redeemed_ready. Clear live, advance head, decrement count.
- Dequeue (silent): count != 0 && !entry[head].live. Advance head without a handshake; at most one entry per cycle.
- A committed but not-yet-accepted head blocks the queue; the head holds while i_redeemed_ready = 0. Abandon may clear entries behind the head; they are skipped silently later.
- Simultaneous enqueue and dequeue: count unchanged. Enqueue into a full queue is impossible because ready is low, even if a dequeue happens in the same cycle (no bypass).
- Enqueue into an empty queue: entry reaches the head next cycle; no same-cycle passthrough.
- Wrap-around: pointers wrap modulo DEPTH. Full is identified by count == DEPTH, never by pointer equality.
- Reset asserted mid-operation: all pending entries are lost. This is correct because the freelist is reset in the same event.

Decomposition:
- Shared issue_rat package holds PRF_WIDTH, FGR_WIDTH, and the entry struct type (prf, fgr, live, committed), all reused with issue_rat_freelist.
- No sub-module. The tag-match logic (compare against commit and abandon FGRs across all entries) is a single generate loop inside the block.

Test Plan:
- Release prf=5, fgr=3, speculative=0 into an empty queue with ready=1 -> o_redeemed_valid=1, o_redeemed_prf=5 the next cycle; after accept, count=0.
- Release prf=9, fgr=2, speculative=1 -> valid stays 0; commit fgr=2 -> valid=1, prf=9 one cycle later.
- Release prf=10, fgr=4, speculative=1, then release prf=11, fgr=5, speculative=0, then abandon fgr=4 -> entry 10 is skipped silently; the only output is prf=11, one cycle after the skip.
- Fill 8 entries with i_redeemed_ready=0 -> o_release_ready=0 with count=8. A 9th release is held. Pop one -> ready=1 the next cycle. Continue for 20 cycles so pointers wrap; output order equals input order.
- In one cycle: release prf=7, fgr=6, speculative=1 together with commit fgr=6 -> entry stored committed; prf=7 output the next cycle.
- Assert reset with 3 committed entries pending -> valid=0 and ready=1 immediately (asynchronous); after release, the queue is empty and nothing is emitted.

Source files
------------

// File: rtl/issue_rat_redeem_queue_pkg.sv
// Shared types for the rename-side PRF redeem queue: register/tag widths and
// the queue entry layout also used by issue_rat_freelist.
package issue_rat_redeem_queue_pkg;

  localparam int unsigned PRF_WIDTH = 6;
  localparam int unsigned FGR_WIDTH = 4;

  typedef logic [PRF_WIDTH-1:0] prf_t;
  typedef logic [FGR_WIDTH-1:0] fgr_t;

  typedef struct packed {
    prf_t prf;
    fgr_t fgr;
    logic live;
    logic committed;
  } rq_entry_t;

  // Build a freshly released entry. A same-cycle abandon kills it and
  // suppresses any same-cycle commit of the same tag.
  function automatic rq_entry_t make_entry(
    input prf_t prf,
    input fgr_t fgr,
    input logic speculative,
    input logic commit_hit,
    input logic abandon_hit
  );
    rq_entry_t e;
    e.prf       = prf;
    e.fgr       = fgr;
    e.live      = !abandon_hit;
    e.committed = !speculative || (commit_hit && !abandon_hit);
    return e;
  endfunction

endpackage

// File: rtl/issue_rat_redeem_queue_if.sv
// Release / redeem / commit / abandon signal bundle for issue_rat_redeem_queue.
interface issue_rat_redeem_queue_if;
  import issue_rat_redeem_queue_pkg::*;

  prf_t i_release_prf;
  fgr_t i_release_fgr;
  logic i_release_speculative;
  logic i_release_valid;
  logic o_release_ready;

  prf_t o_redeemed_prf;
  logic o_redeemed_valid;
  logic i_redeemed_ready;

  fgr_t i_commit_fgr;
  logic i_commit_valid;
  fgr_t i_abandon_fgr;
  logic i_abandon_valid;

  // Queue side
  modport slave (
    input  i_release_prf, i_release_fgr, i_release_speculative, i_release_valid,
    output o_release_ready,
    output o_redeemed_prf, o_redeemed_valid,
    input  i_redeemed_ready,
    input  i_commit_fgr, i_commit_valid, i_abandon_fgr, i_abandon_valid
  );

  // Rename / freelist / retire side
  modport master (
    output i_release_prf, i_release_fgr, i_release_speculative, i_release_valid,
    input  o_release_ready,
    input  o_redeemed_prf, o_redeemed_valid,
    output i_redeemed_ready,
    output i_commit_fgr, i_commit_valid, i_abandon_fgr, i_abandon_valid
  );
endinterface

// File: rtl/issue_rat_redeem_queue.sv
// Holds PRFs released at rename until their FGR commits (then hands them to the
// freelist in order) or is abandoned (then skips them silently).
module issue_rat_redeem_queue
  import issue_rat_redeem_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input logic                     clk,
  input logic                     reset,
  issue_rat_redeem_queue_if.slave rq
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  rq_entry_t        entries_q [DEPTH];
  rq_entry_t        entries_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [DEPTH-1:0] commit_hit;
  logic [DEPTH-1:0] abandon_hit;
  logic [DEPTH-1:0] live_upd;
  logic [DEPTH-1:0] committed_upd;

  logic      not_empty;
  logic      head_valid;
  logic      enq;
  logic      deq_hs;
  logic      deq_silent;
  logic      deq;
  rq_entry_t new_entry;

  // Per-entry tag match against the commit and abandon broadcasts
  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    assign commit_hit[g]  = rq.i_commit_valid && entries_q[g].live
                            && (entries_q[g].fgr == rq.i_commit_fgr);
    assign abandon_hit[g] = rq.i_abandon_valid && entries_q[g].live
                            && !entries_q[g].committed
                            && (entries_q[g].fgr == rq.i_abandon_fgr);
    assign live_upd[g]      = entries_q[g].live && !abandon_hit[g];
    assign committed_upd[g] = entries_q[g].committed
                              || (commit_hit[g] && !abandon_hit[g]);
  end

  // Head status and handshakes, all from registered state
  assign not_empty  = (count_q != CNT_W'(0));
  assign head_valid = not_empty && entries_q[head_q].live && entries_q[head_q].committed;

  assign rq.o_release_ready  = (count_q != CNT_W'(DEPTH));
  assign rq.o_redeemed_valid = head_valid;
  assign rq.o_redeemed_prf   = head_valid ? entries_q[head_q].prf : '0;

  assign enq        = rq.i_release_valid && rq.o_release_ready;
  assign deq_hs     = head_valid && rq.i_redeemed_ready;
  assign deq_silent = not_empty && !entries_q[head_q].live;
  assign deq        = deq_hs || deq_silent;

  assign new_entry = make_entry(
    rq.i_release_prf,
    rq.i_release_fgr,
    rq.i_release_speculative,
    rq.i_commit_valid && (rq.i_commit_fgr == rq.i_release_fgr),
    rq.i_abandon_valid && (rq.i_abandon_fgr == rq.i_release_fgr)
  );

  // Next-state: tag updates first, then dequeue clear, then the enqueue write
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i]           = entries_q[i];
      entries_d[i].live      = live_upd[i];
      entries_d[i].committed = committed_upd[i];
    end
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (deq_hs) begin
      entries_d[head_q].live = 1'b0;
    end
    if (deq) begin
      head_d = head_q + PTR_W'(1);
    end
    if (enq) begin
      entries_d[tail_q] = new_entry;
      tail_d            = tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_issue_rat_redeem_queue.sv
// Directed bench for issue_rat_redeem_queue; a negedge monitor checks every
// accepted redeem against a queue of expected PRFs in release order.
module tb_issue_rat_redeem_queue;
  import issue_rat_redeem_queue_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   sb[$];

  issue_rat_redeem_queue_if rq ();

  issue_rat_redeem_queue #(.DEPTH(8)) dut (
    .clk  (clk),
    .reset(reset),
    .rq   (rq.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rq.i_release_valid       = 1'b0;
    rq.i_release_prf         = '0;
    rq.i_release_fgr         = '0;
    rq.i_release_speculative = 1'b0;
    rq.i_commit_valid        = 1'b0;
    rq.i_commit_fgr          = '0;
    rq.i_abandon_valid       = 1'b0;
    rq.i_abandon_fgr         = '0;
  endtask

  task automatic release_drive(input int prf, input int fgr, input logic spec);
    rq.i_release_valid       = 1'b1;
    rq.i_release_prf         = PRF_WIDTH'(prf);
    rq.i_release_fgr         = FGR_WIDTH'(fgr);
    rq.i_release_speculative = spec;
  endtask

  // Scoreboard monitor: every accepted redeem must match the oldest expectation
  always @(negedge clk) begin
    if (reset && rq.o_redeemed_valid && rq.i_redeemed_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL redeem_unexpected: got prf %0d expected none", rq.o_redeemed_prf);
      end else begin
        check("redeem_prf", int'(rq.o_redeemed_prf), sb.pop_front());
      end
    end
    if (rq.i_commit_valid && rq.i_abandon_valid && rq.i_commit_fgr == rq.i_abandon_fgr) begin
      failures++;
      $display("FAIL illegal_commit_abandon: got fgr %0d on both strobes expected distinct",
               rq.i_commit_fgr);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prf;
    int waited;
    checks   = 0;
    failures = 0;
    idle();
    rq.i_redeemed_ready = 1'b1;
    reset = 1'b0;
    #12;
    check("rst_valid", int'(rq.o_redeemed_valid), 0);
    check("rst_prf", int'(rq.o_redeemed_prf), 0);
    check("rst_ready", int'(rq.o_release_ready), 1);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Non-speculative release into empty queue
    release_drive(5, 3, 1'b0);
    sb.push_back(5);
    tick();
    idle();
    check("t1_valid", int'(rq.o_redeemed_valid), 1);
    check("t1_prf", int'(rq.o_redeemed_prf), 5);
    tick();
    check("t1_drained_valid", int'(rq.o_redeemed_valid), 0);
    check("t1_drained_ready", int'(rq.o_release_ready), 1);

    // Speculative release waits for commit
    release_drive(9, 2, 1'b1);
    tick();
    idle();
    check("t2_spec_hold0", int'(rq.o_redeemed_valid), 0);
    tick();
    check("t2_spec_hold1", int'(rq.o_redeemed_valid), 0);
    rq.i_commit_valid = 1'b1;
    rq.i_commit_fgr   = 4'd2;
    sb.push_back(9);
    tick();
    idle();
    check("t2_commit_valid", int'(rq.o_redeemed_valid), 1);
    check("t2_commit_prf", int'(rq.o_redeemed_prf), 9);
    tick();
    check("t2_after", int'(rq.o_redeemed_valid), 0);

    // Abandoned head skipped silently
    release_drive(10, 4, 1'b1);
    tick();
    release_drive(11, 5, 1'b0);
    sb.push_back(11);
    tick();
    idle();
    check("t3_blocked", int'(rq.o_redeemed_valid), 0);
    rq.i_abandon_valid = 1'b1;
    rq.i_abandon_fgr   = 4'd4;
    tick();
    idle();
    check("t3_dead_head", int'(rq.o_redeemed_valid), 0);
    tick();
    check("t3_skip_valid", int'(rq.o_redeemed_valid), 1);
    check("t3_skip_prf", int'(rq.o_redeemed_prf), 11);
    tick();
    check("t3_after", int'(rq.o_redeemed_valid), 0);

    // Fill to full, hold a 9th release, then stream through wrap-around
    rq.i_redeemed_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t4_fill_ready", int'(rq.o_release_ready), 1);
      release_drive(20 + i, 1, 1'b0);
      sb.push_back(20 + i);
      tick();
    end
    check("t4_full_ready", int'(rq.o_release_ready), 0);
    check("t4_full_head", int'(rq.o_redeemed_prf), 20);
    release_drive(28, 1, 1'b0);
    tick();
    tick();
    check("t4_held_ready", int'(rq.o_release_ready), 0);
    rq.i_redeemed_ready = 1'b1;
    tick();
    check("t4_pop_ready", int'(rq.o_release_ready), 1);
    prf = 28;
    for (int i = 0; i < 20; i++) begin
      check("t4_stream_ready", int'(rq.o_release_ready), 1);
      release_drive(prf, 1, 1'b0);
      sb.push_back(prf);
      tick();
      prf++;
    end
    idle();
    waited = 0;
    while (sb.size() != 0 && waited < 40) begin
      tick();
      waited++;
    end
    check("t4_drain_left", sb.size(), 0);
    tick();
    check("t4_empty_valid", int'(rq.o_redeemed_valid), 0);

    // Release and commit of the same tag in one cycle
    release_drive(7, 6, 1'b1);
    rq.i_commit_valid = 1'b1;
    rq.i_commit_fgr   = 4'd6;
    sb.push_back(7);
    tick();
    idle();
    check("t5_valid", int'(rq.o_redeemed_valid), 1);
    check("t5_prf", int'(rq.o_redeemed_prf), 7);
    tick();
    check("t5_after", int'(rq.o_redeemed_valid), 0);

    // Asynchronous reset with committed entries pending
    rq.i_redeemed_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      release_drive(30 + i, 7, 1'b0);
      tick();
    end
    idle();
    check("t6_pending_valid", int'(rq.o_redeemed_valid), 1);
    check("t6_pending_prf", int'(rq.o_redeemed_prf), 30);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_valid", int'(rq.o_redeemed_valid), 0);
    check("t6_rst_prf", int'(rq.o_redeemed_prf), 0);
    check("t6_rst_ready", int'(rq.o_release_ready), 1);
    tick();
    @(negedge clk);
    reset = 1'b1;
    rq.i_redeemed_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_post_valid", int'(rq.o_redeemed_valid), 0);
    end
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
